// File: rtl/xor_fold_stream_pkg.sv
// Shared types and helpers for the streaming XOR folder.
package xor_fold_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic int unsigned fold_ratio(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/xor_fold_stream_if.sv
// Input beat stream and folded result stream sharing one bundle.
interface xor_fold_stream_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned CNT_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*IN_W-1:0]    in_data;
  logic                  in_last;
  logic                  mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*OUT_W-1:0]   out_data;
  logic [CNT_W-1:0]      out_cnt;

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/xor_fold_stream_slice.sv
// One channel: XOR of all OUT_W-wide slices of an IN_W-wide word.
module xor_fold_slice
  import xor_fold_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  data,
  output logic [OUT_W-1:0] folded
);
  localparam int unsigned RATIO = fold_ratio(IN_W, OUT_W);

  always_comb begin
    folded = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      folded = folded ^ data[k*OUT_W +: OUT_W];
    end
  end
endmodule

// File: rtl/xor_fold_stream.sv
// Streaming multi-channel XOR folder with per-beat and frame-accumulate modes.
module xor_fold_stream
  import xor_fold_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  xor_fold_stream_if.slave bus
);
  localparam int unsigned DW      = CH * OUT_W;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

  if ((IN_W % OUT_W) != 0 || OUT_W > IN_W) begin : g_bad_cfg
    $error("xor_fold_stream: IN_W must be a non-zero multiple of OUT_W");
  end

  state_t             state, state_next;
  logic [DW-1:0]      acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic               frame_mode, frame_mode_next;
  logic               out_valid, load, in_ready, accept;
  logic [DW-1:0]      out_data, load_data, folded;
  logic [CNT_W-1:0]   out_cnt, load_cnt;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    xor_fold_slice #(.IN_W(IN_W), .OUT_W(OUT_W)) u_slice (
      .data   (bus.in_data[c*IN_W +: IN_W]),
      .folded (folded[c*OUT_W +: OUT_W])
    );
  end

  // Non-last ACC beats only update the accumulator, so they may enter under backpressure.
  assign in_ready = !rst && (!out_valid || bus.out_ready || (state == ACC && !bus.in_last));
  assign accept   = bus.in_valid && in_ready;
  assign cnt_inc  = CNT_W'(sat_inc(32'(cnt), CNT_MAX));

  always_comb begin
    state_next      = state;
    acc_next        = acc;
    cnt_next        = cnt;
    frame_mode_next = frame_mode;
    load            = 1'b0;
    load_data       = '0;
    load_cnt        = '0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!bus.mode || bus.in_last) begin
            load      = 1'b1;
            load_data = folded;
            load_cnt  = CNT_W'(1);
          end else begin
            state_next      = ACC;
            acc_next        = folded;
            cnt_next        = CNT_W'(1);
            frame_mode_next = 1'b1;
          end
        end
        ACC: begin
          if (bus.in_last) begin
            load            = 1'b1;
            load_data       = acc ^ folded;
            load_cnt        = cnt_inc;
            acc_next        = '0;
            cnt_next        = '0;
            frame_mode_next = 1'b0;
            state_next      = IDLE;
          end else begin
            acc_next = acc ^ folded;
            cnt_next = cnt_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      frame_mode <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cnt    <= '0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      cnt        <= cnt_next;
      frame_mode <= frame_mode_next;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_cnt   <= load_cnt;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_cnt   = out_cnt;
endmodule

// File: tb/tb_xor_fold_stream.sv
// Randomized and directed checks of xor_fold_stream against a frame-level reference model.
module tb_xor_fold_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  xor_fold_stream_if #(.IN_W(16), .OUT_W(8), .CH(2), .CNT_W(8)) ifa ();
  xor_fold_stream_if #(.IN_W(16), .OUT_W(8), .CH(2), .CNT_W(4)) ifb ();
  xor_fold_stream_if #(.IN_W(32), .OUT_W(8), .CH(1), .CNT_W(8)) ifc ();

  xor_fold_stream #(.IN_W(16), .OUT_W(8), .CH(2), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  xor_fold_stream #(.IN_W(16), .OUT_W(8), .CH(2), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  xor_fold_stream #(.IN_W(32), .OUT_W(8), .CH(1), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each 16-bit channel folds to the XOR of its two bytes.
  function automatic logic [15:0] ref_fold16(input logic [31:0] d);
    return {d[31:24] ^ d[23:16], d[15:8] ^ d[7:0]};
  endfunction

  function automatic logic [7:0] ref_fold32(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  // Model of instance A: pending result plus the beats of any open frame.
  logic        m_ov = 1'b0;
  logic [15:0] m_od = '0;
  logic [7:0]  m_oc = '0;
  logic        m_open = 1'b0;
  logic [31:0] beats[$];

  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic l, input logic m, input logic o);
    logic        exp_rdy;
    logic [15:0] sig;
    @(negedge clk);
    rst = r;
    ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l; ifa.mode = m; ifa.out_ready = o;
    #1;
    exp_rdy = !r && (!m_ov || o || (m_open && !l));
    check_eq("in_ready", ifa.in_ready, exp_rdy);
    if (r) begin
      m_ov = 1'b0; m_od = '0; m_oc = '0; m_open = 1'b0; beats.delete();
    end else begin
      if (m_ov && o) m_ov = 1'b0;
      if (v && exp_rdy) begin
        beats.push_back(d);
        if (m_open || (m && !l)) m_open = 1'b1;
        if (!m_open || l) begin
          sig = '0;
          foreach (beats[i]) sig = sig ^ ref_fold16(beats[i]);
          m_ov = 1'b1;
          m_od = sig;
          m_oc = (beats.size() > 255) ? 8'd255 : 8'(beats.size());
          m_open = 1'b0;
          beats.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", ifa.out_valid, m_ov);
    check_eq("out_data", ifa.out_data, m_od);
    check_eq("out_cnt", ifa.out_cnt, m_oc);
  endtask

  initial begin
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_last = 0; ifa.mode = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.in_last = 0; ifb.mode = 0; ifb.out_ready = 0;
    ifc.in_valid = 0; ifc.in_data = '0; ifc.in_last = 0; ifc.mode = 0; ifc.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ov", ifa.out_valid, 1'b0);
    check_eq("rst_od", ifa.out_data, 16'h0);
    check_eq("rst_oc", ifa.out_cnt, 8'h0);
    check_eq("rst_rdy", ifa.in_ready, 1'b0);

    // Mode 0 single beat and back-to-back streaming.
    step(0, 1, 32'hFF00_12F0, 0, 0, 1);
    check_eq("m0_data", ifa.out_data, 16'hFFE2);
    check_eq("m0_cnt", ifa.out_cnt, 8'd1);
    step(0, 1, 32'h1234_5678, 1, 0, 1);
    step(0, 1, 32'hA5A5_0F0F, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // Backpressure: second beat waits until the first result leaves.
    step(0, 1, 32'h0000_00AA, 0, 0, 0);
    step(0, 1, 32'h0000_BB00, 0, 0, 0);
    check_eq("bp_hold", ifa.out_data, 16'h00AA);
    step(0, 1, 32'h0000_BB00, 0, 0, 0);
    step(0, 1, 32'h0000_BB00, 0, 0, 1);
    check_eq("bp_next", ifa.out_data, 16'h00BB);
    step(0, 0, 32'h0, 0, 0, 1);

    // Mode 1 three-beat frame.
    step(0, 1, 32'h0000_0101, 0, 1, 1);
    check_eq("f_nov1", ifa.out_valid, 1'b0);
    step(0, 1, 32'h0000_0202, 0, 1, 1);
    check_eq("f_nov2", ifa.out_valid, 1'b0);
    step(0, 1, 32'h0000_0403, 1, 1, 1);
    check_eq("f_data", ifa.out_data, 16'h0007);
    check_eq("f_cnt", ifa.out_cnt, 8'd3);
    step(0, 0, 32'h0, 0, 0, 1);

    // Reset mid-frame discards the partial frame.
    step(0, 1, 32'h0000_0101, 0, 1, 1);
    step(0, 1, 32'h0000_0202, 0, 1, 1);
    step(1, 0, 32'h0, 0, 0, 1);
    check_eq("rmf_ov", ifa.out_valid, 1'b0);
    step(0, 1, 32'h0000_00AA, 0, 0, 1);
    check_eq("rmf_data", ifa.out_data, 16'h00AA);
    check_eq("rmf_cnt", ifa.out_cnt, 8'd1);

    // Randomized traffic, including occasional resets and long frames.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), $urandom(),
           ($urandom_range(0, 9) < 2), $urandom_range(0, 1), ($urandom_range(0, 9) < 6));
    end
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // CNT_W=4 saturation over a 20-beat frame.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ifb.in_valid = 1; ifb.in_data = 32'h0000_0001; ifb.mode = 1;
      ifb.in_last = (i == 19); ifb.out_ready = 1;
      #1;
      check_eq("b_rdy", ifb.in_ready, 1'b1);
      @(posedge clk);
      #1;
      if (i < 19) check_eq("b_nov", ifb.out_valid, 1'b0);
    end
    check_eq("b_ov", ifb.out_valid, 1'b1);
    check_eq("b_cnt", ifb.out_cnt, 4'd15);
    check_eq("b_data", ifb.out_data, 16'h0000);
    @(negedge clk);
    ifb.in_valid = 0;

    // 32->8 single-channel fold.
    @(negedge clk);
    ifc.in_valid = 1; ifc.in_data = 32'h1122_3344; ifc.mode = 0; ifc.in_last = 0; ifc.out_ready = 1;
    @(posedge clk);
    #1;
    check_eq("c_data", ifc.out_data, 8'h44);
    check_eq("c_cnt", ifc.out_cnt, 8'd1);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] d;
      d = $urandom();
      @(negedge clk);
      ifc.in_data = d; ifc.mode = 0;
      @(posedge clk);
      #1;
      check_eq("c_rand", ifc.out_data, ref_fold32(d));
    end
    @(negedge clk);
    ifc.in_valid = 0;
    @(posedge clk);
    #1;
    check_eq("c_drop", ifc.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
